led_chase_monitor: RTL and testbench

LED_CHASE_MONITOR -- requirements
Module: led_chase_monitor

---
 rtl/led_chase_monitor.sv | 158 +++++++++++++++
 tb/tb_led_chase_monitor.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/led_chase_monitor.sv
// Watches an 8-bit LED chase pattern, locks onto a steady one-hot walk in one
// direction, counts completed laps while locked, and flags and counts lock losses.
module led_chase_monitor #(
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] q_in,
  output logic [2:0] pos,
  output logic       dir,
  output logic       locked,
  output logic [7:0] lap_count,
  output logic       err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);

  state_t     state, state_n;
  logic [2:0] good_cnt, good_cnt_n;
  logic [2:0] pos_n;
  logic       dir_n;
  logic       locked_n;
  logic [7:0] lap_n;
  logic       err_n;
  logic [7:0] errc_n;

  // Sample decode: one-hot detection and bit index of the lit LED.
  logic [3:0] ones;
  logic [2:0] p;
  logic       one_hot;

  always_comb begin
    ones = 4'd0;
    p    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (q_in[i]) begin
        ones = ones + 4'd1;
        p    = 3'(i);
      end
    end
    one_hot = (ones == 4'd1);
  end

  // Step classification against the stored position; 3-bit arithmetic wraps mod 8.
  logic [2:0] pos_up, pos_dn;
  logic       is_hold, is_up, is_down, step_fwd, at_wrap;

  always_comb begin
    pos_up   = pos + 3'd1;
    pos_dn   = pos - 3'd1;
    is_hold  = one_hot && (p == pos);
    is_up    = one_hot && (p == pos_up);
    is_down  = one_hot && (p == pos_dn);
    step_fwd = dir ? is_up : is_down;
    at_wrap  = dir ? (pos == 3'd7) : (pos == 3'd0);
  end

  // Next-state and next-output logic; err defaults low so it can only pulse.
  always_comb begin
    state_n    = state;
    good_cnt_n = good_cnt;
    pos_n      = pos;
    dir_n      = dir;
    lap_n      = lap_count;
    err_n      = 1'b0;
    errc_n     = err_count;

    if (enable) begin
      case (state)
        IDLE: begin
          if (one_hot) begin
            pos_n      = p;
            good_cnt_n = 3'd0;
            state_n    = ACQUIRE;
          end
        end

        ACQUIRE: begin
          if (is_hold) begin
            state_n = ACQUIRE;
          end else if ((good_cnt == 3'd0 && (is_up || is_down)) ||
                       (good_cnt != 3'd0 && step_fwd)) begin
            // The first step of an acquisition chooses the direction.
            if (good_cnt == 3'd0) begin
              dir_n = is_up;
            end
            pos_n      = p;
            good_cnt_n = good_cnt + 3'd1;
            if (good_cnt_n == LOCK_TGT) begin
              state_n    = LOCKED;
              lap_n      = 8'd0;
              good_cnt_n = 3'd0;
            end
          end else if (one_hot) begin
            pos_n      = p;
            good_cnt_n = 3'd0;
          end else begin
            good_cnt_n = 3'd0;
            state_n    = IDLE;
          end
        end

        LOCKED: begin
          if (is_hold) begin
            state_n = LOCKED;
          end else if (step_fwd) begin
            pos_n = p;
            if (at_wrap) begin
              lap_n = lap_count + 8'd1;
            end
          end else begin
            err_n   = 1'b1;
            errc_n  = (err_count == 8'hff) ? err_count : err_count + 8'd1;
            state_n = IDLE;
          end
        end

        default: begin
          state_n    = IDLE;
          good_cnt_n = 3'd0;
        end
      endcase
    end

    locked_n = (state_n == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      good_cnt  <= 3'd0;
      pos       <= 3'd0;
      dir       <= 1'b1;
      locked    <= 1'b0;
      lap_count <= 8'd0;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state     <= state_n;
      good_cnt  <= good_cnt_n;
      pos       <= pos_n;
      dir       <= dir_n;
      locked    <= locked_n;
      lap_count <= lap_n;
      err       <= err_n;
      err_count <= errc_n;
    end
  end

endmodule

// File: tb/tb_led_chase_monitor.sv
// Directed bench for led_chase_monitor: the driver pushes hand-computed expected
// outputs per sample; a monitor pops and compares one clock after capture.
module tb_led_chase_monitor;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] q_in;
  logic [2:0] pos;
  logic       dir;
  logic       locked;
  logic [7:0] lap_count;
  logic       err;
  logic [7:0] err_count;

  led_chase_monitor #(.LOCK_CNT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .q_in      (q_in),
    .pos       (pos),
    .dir       (dir),
    .locked    (locked),
    .lap_count (lap_count),
    .err       (err),
    .err_count (err_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {pos, dir, locked, lap_count, err, err_count}
  logic [21:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad   = 0;

  // Driver: one sample per clock, expected outputs pushed alongside.
  task automatic drive(input logic r, input logic e, input logic [7:0] q,
                       input logic [2:0] ep, input logic ed, input logic el,
                       input logic [7:0] elap, input logic ee, input logic [7:0] eec,
                       input string nm);
    @(negedge clk);
    reset  = r;
    enable = e;
    q_in   = q;
    exp_q.push_back({ep, ed, el, elap, ee, eec});
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are checked 1 time unit after the capturing edge.
  always @(posedge clk) begin
    logic [21:0] exp_v;
    logic [21:0] got_v;
    string       nm;
    #1;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got_v = {pos, dir, locked, lap_count, err, err_count};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL %s: got pos=%0d dir=%0d locked=%0d lap=%0d err=%0d errc=%0d, want pos=%0d dir=%0d locked=%0d lap=%0d err=%0d errc=%0d",
                 nm, got_v[21:19], got_v[18], got_v[17], got_v[16:9], got_v[8], got_v[7:0],
                 exp_v[21:19], exp_v[18], exp_v[17], exp_v[16:9], exp_v[8], exp_v[7:0]);
      end
    end
  end

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    q_in   = 8'h00;

    drive(0, 1, 8'h55, 0, 1, 0, 0, 0, 0, "reset_a");
    drive(0, 0, 8'h01, 0, 1, 0, 0, 0, 0, "reset_b");

    // Lock up
    drive(1, 1, 8'h01, 0, 1, 0, 0, 0, 0, "acq_p0");
    drive(1, 1, 8'h02, 1, 1, 0, 0, 0, 0, "acq_p1");
    drive(1, 1, 8'h04, 2, 1, 1, 0, 0, 0, "lock_up");

    // Two laps upward
    for (int i = 3; i < 8; i++) drive(1, 1, 8'h01 << i, 3'(i), 1, 1, 0, 0, 0, "lap1_step");
    drive(1, 1, 8'h01, 0, 1, 1, 1, 0, 0, "lap1_wrap");
    for (int i = 1; i < 8; i++) drive(1, 1, 8'h01 << i, 3'(i), 1, 1, 1, 0, 0, "lap2_step");
    drive(1, 1, 8'h01, 0, 1, 1, 2, 0, 0, "lap2_wrap");
    drive(1, 1, 8'h02, 1, 1, 1, 2, 0, 0, "to_p1");
    drive(1, 1, 8'h04, 2, 1, 1, 2, 0, 0, "to_p2");

    // Jump while locked, then invalid sample in acquisition
    drive(1, 1, 8'h10, 2, 1, 0, 2, 1, 1, "jump_err");
    drive(1, 0, 8'h10, 2, 1, 0, 2, 0, 1, "err_one_cycle");
    drive(1, 1, 8'h01, 0, 1, 0, 2, 0, 1, "reacq");
    drive(1, 1, 8'h03, 0, 1, 0, 2, 0, 1, "acq_invalid_no_err");

    // Enable gating
    drive(1, 0, 8'hff, 0, 1, 0, 2, 0, 1, "gate_ff");
    drive(1, 0, 8'h80, 0, 1, 0, 2, 0, 1, "gate_80");
    drive(1, 0, 8'h02, 0, 1, 0, 2, 0, 1, "gate_02");

    drive(0, 1, 8'h01, 0, 1, 0, 0, 0, 0, "reset_clear");

    // Down with a hold
    drive(1, 1, 8'h80, 7, 1, 0, 0, 0, 0, "down_p7");
    drive(1, 1, 8'h40, 6, 0, 0, 0, 0, 0, "down_p6");
    drive(1, 1, 8'h40, 6, 0, 0, 0, 0, 0, "down_hold");
    drive(1, 1, 8'h20, 5, 0, 1, 0, 0, 0, "lock_down");
    for (int i = 4; i >= 0; i--) drive(1, 1, 8'h01 << i, 3'(i), 0, 1, 0, 0, 0, "down_step");
    drive(1, 1, 8'h80, 7, 0, 1, 1, 0, 0, "down_wrap");

    // Step against direction while locked, then restart inside acquisition
    drive(1, 1, 8'h01, 7, 0, 0, 1, 1, 1, "against_dir_err");
    drive(1, 1, 8'h02, 1, 0, 0, 1, 0, 1, "idle_to_acq");
    drive(1, 1, 8'h04, 2, 1, 0, 1, 0, 1, "acq_up_first");
    drive(1, 1, 8'h02, 1, 1, 0, 1, 0, 1, "acq_restart_no_err");
    drive(1, 1, 8'h01, 0, 0, 0, 1, 0, 1, "acq_down_first");
    drive(1, 1, 8'h80, 7, 0, 1, 0, 0, 1, "relock_lap_clear");

    // Three down laps, then reset mid-lock
    for (int l = 1; l <= 3; l++) begin
      for (int i = 6; i >= 0; i--) drive(1, 1, 8'h01 << i, 3'(i), 0, 1, 8'(l - 1), 0, 1, "down_lap_step");
      drive(1, 1, 8'h80, 7, 0, 1, 8'(l), 0, 1, "down_lap_wrap");
    end
    drive(0, 1, 8'h40, 0, 1, 0, 0, 0, 0, "reset_mid_lock");
    drive(1, 0, 8'h40, 0, 1, 0, 0, 0, 0, "post_reset_hold");

    // 256 forced lock losses; err_count saturates at 255
    for (int k = 1; k <= 256; k++) begin
      logic [7:0] prev_c, cur_c;
      prev_c = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
      cur_c  = (k > 255) ? 8'd255 : 8'(k);
      drive(1, 1, 8'h01, 0, 1, 0, 0, 0, prev_c, "sat_acq0");
      drive(1, 1, 8'h02, 1, 1, 0, 0, 0, prev_c, "sat_acq1");
      drive(1, 1, 8'h04, 2, 1, 1, 0, 0, prev_c, "sat_lock");
      drive(1, 1, 8'h10, 2, 1, 0, 0, 1, cur_c, "sat_loss");
    end
    drive(1, 0, 8'h00, 2, 1, 0, 0, 0, 255, "sat_hold");

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
